// File: rtl/fifo_stage.sv
// fifo_stage
// First-word-fall-through FIFO that feeds the data input of a SIZE-bit
// flip-flop stage. The head entry is always presented on data_o, so the
// downstream register can sample it on any clock edge.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset_i      asynchronous, active-high reset
//   write_i      push request, data_i is enqueued when the FIFO is not full
//   data_i       push data (SIZE bits)
//   read_i       pop request, head is removed when the FIFO is not empty
//   data_o       head entry, or 0 while empty
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
//   count_o      occupancy, 0..DEPTH
//   overflow_o   one-cycle strobe: a write was rejected on the previous edge
//   underflow_o  one-cycle strobe: a read was rejected on the previous edge
module fifo_stage #(
  parameter int SIZE  = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     write_i,
  input  logic [SIZE-1:0]          data_i,
  input  logic                     read_i,
  output logic [SIZE-1:0]          data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            write_accept;
  logic            read_accept;

  // Status flags come only from the registered count, so there is no
  // combinational path from the request inputs to full/empty.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Requests are judged against the state held before the edge. A full
  // FIFO never bypasses a write through a read, and an empty FIFO never
  // lets a read fall through to the data being written.
  assign write_accept = write_i && !full_o;
  assign read_accept  = read_i && !empty_o;

  // Head is gated while empty so stale or uninitialised storage never leaks.
  assign data_o = empty_o ? '0 : mem[rd_ptr];

  // Storage is intentionally not reset; the empty gate above hides it.
  always_ff @(posedge clk) begin
    if (write_accept) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (write_accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (read_accept) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy tracks the net effect of the accepted operations.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      case ({write_accept, read_accept})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Error strobes are re-evaluated every edge, so each one lasts exactly
  // one cycle unless the rejected request is repeated.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= write_i && full_o;
      underflow_o <= read_i && empty_o;
    end
  end

endmodule

// File: tb/tb_fifo_stage.sv
// tb_fifo_stage
// Directed bench for fifo_stage (SIZE=8, DEPTH=4). A queue-based reference
// model tracks the expected contents and strobes; a compare process checks
// every output on each falling edge, and literal expectations pin the model.
module tb_fifo_stage;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   reset_i;
  logic                   write_i;
  logic [SIZE-1:0]        data_i;
  logic                   read_i;
  logic [SIZE-1:0]        data_o;
  logic                   full_o;
  logic                   empty_o;
  logic [$clog2(DEPTH):0] count_o;
  logic                   overflow_o;
  logic                   underflow_o;

  int checks = 0;
  int errors = 0;

  logic [SIZE-1:0] model_q [$];
  bit              model_valid = 0;
  bit              exp_over;
  bit              exp_under;
  bit              model_wa;
  bit              model_ra;

  fifo_stage #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .write_i     (write_i),
    .data_i      (data_i),
    .read_i      (read_i),
    .data_o      (data_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Drive one request at the falling edge, let the rising edge take it,
  // then return the inputs to idle (data_i deliberately X while idle).
  task automatic applyStimulus(input logic w, input logic [SIZE-1:0] d, input logic r);
    @(negedge clk);
    write_i = w;
    data_i  = d;
    read_i  = r;
    @(posedge clk);
    #1;
    write_i = 1'b0;
    read_i  = 1'b0;
    data_i  = 'x;
  endtask

  // Reference model: a plain queue with the accept rules applied to the
  // occupancy seen before the edge.
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      model_q.delete();
      exp_over    = 1'b0;
      exp_under   = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      model_wa  = write_i && (model_q.size() != DEPTH);
      model_ra  = read_i && (model_q.size() != 0);
      exp_over  = write_i && (model_q.size() == DEPTH);
      exp_under = read_i && (model_q.size() == 0);
      if (model_ra) void'(model_q.pop_front());
      if (model_wa) model_q.push_back(data_i);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid && !reset_i) begin
      checkOutput("count", 32'(count_o), 32'(model_q.size()));
      checkOutput("empty", 32'(empty_o), 32'(model_q.size() == 0));
      checkOutput("full", 32'(full_o), 32'(model_q.size() == DEPTH));
      checkOutput("data", 32'(data_o), (model_q.size() == 0) ? 32'h0 : 32'(model_q[0]));
      checkOutput("overflow", 32'(overflow_o), 32'(exp_over));
      checkOutput("underflow", 32'(underflow_o), 32'(exp_under));
    end
  end

  initial begin
    logic [SIZE-1:0] fill_vals [4];
    fill_vals[0] = 8'hA1;
    fill_vals[1] = 8'hB2;
    fill_vals[2] = 8'hC3;
    fill_vals[3] = 8'hD4;

    reset_i = 1'b0;
    write_i = 1'b0;
    read_i  = 1'b0;
    data_i  = '0;

    // Asynchronous reset between clock edges.
    #2 reset_i = 1'b1;
    #1;
    $display("[TB] reset checks");
    checkOutput("rst_count", 32'(count_o), 32'd0);
    checkOutput("rst_empty", 32'(empty_o), 32'd1);
    checkOutput("rst_full", 32'(full_o), 32'd0);
    checkOutput("rst_data", 32'(data_o), 32'h00);
    checkOutput("rst_over", 32'(overflow_o), 32'd0);
    checkOutput("rst_under", 32'(underflow_o), 32'd0);
    #19 reset_i = 1'b0;

    // Fill then overflow.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, fill_vals[i], 1'b0);
    checkOutput("fill_full", 32'(full_o), 32'd1);
    checkOutput("fill_count", 32'(count_o), 32'd4);
    checkOutput("fill_head", 32'(data_o), 32'hA1);
    applyStimulus(1'b1, 8'hEE, 1'b0);
    checkOutput("ovf_strobe", 32'(overflow_o), 32'd1);
    checkOutput("ovf_count", 32'(count_o), 32'd4);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovf_clear", 32'(overflow_o), 32'd0);

    // Drain in order; EE must never appear.
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_head", 32'(data_o), 32'(fill_vals[i]));
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("drain_empty", 32'(empty_o), 32'd1);
    checkOutput("drain_data", 32'(data_o), 32'h00);

    // Underflow.
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("unf_strobe", 32'(underflow_o), 32'd1);
    checkOutput("unf_count", 32'(count_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("unf_clear", 32'(underflow_o), 32'd0);

    // Alternating write/read so both pointers wrap several times.
    for (int v = 0; v < 10; v++) begin
      applyStimulus(1'b1, 8'(v), 1'b0);
      checkOutput("wrap_head", 32'(data_o), 32'(v));
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("wrap_empty", 32'(empty_o), 32'd1);

    // Simultaneous on empty: write wins, read rejected.
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("sim_e_count", 32'(count_o), 32'd1);
    checkOutput("sim_e_data", 32'(data_o), 32'h55);
    checkOutput("sim_e_under", 32'(underflow_o), 32'd1);

    // Simultaneous at count 2: occupancy unchanged, head advances.
    applyStimulus(1'b1, 8'h66, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b1);
    checkOutput("sim_2_count", 32'(count_o), 32'd2);
    checkOutput("sim_2_data", 32'(data_o), 32'h66);

    // Simultaneous on full: read wins, write rejected.
    applyStimulus(1'b1, 8'h99, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("sim_f_full", 32'(full_o), 32'd1);
    applyStimulus(1'b1, 8'hBB, 1'b1);
    checkOutput("sim_f_count", 32'(count_o), 32'd3);
    checkOutput("sim_f_over", 32'(overflow_o), 32'd1);
    checkOutput("sim_f_data", 32'(data_o), 32'h88);

    // Reset pulse between edges with three entries queued.
    #2 reset_i = 1'b1;
    #1;
    checkOutput("mid_rst_count", 32'(count_o), 32'd0);
    checkOutput("mid_rst_empty", 32'(empty_o), 32'd1);
    checkOutput("mid_rst_data", 32'(data_o), 32'h00);
    #1 reset_i = 1'b0;
    applyStimulus(1'b1, 8'h77, 1'b0);
    checkOutput("post_rst_data", 32'(data_o), 32'h77);
    checkOutput("post_rst_count", 32'(count_o), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("final_empty", 32'(empty_o), 32'd1);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stage.md
Name: fifo_stage

Overview:
- Parameterised synchronous first-word-fall-through FIFO that sits directly upstream of the SIZE-bit flip-flop stage and feeds its data_i.
- Absorbs bursty producer traffic; exposes head-of-queue data continuously so the downstream register can sample it on any clock edge.
- Provides occupancy and single-cycle error strobes for bench checking.

Parameters:
- SIZE, 1, data width in bits; matches the downstream flip-flop stage width.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- write_i  input  1  push request; data_i is enqueued when accepted.
- data_i  input  SIZE  push data.
- read_i  input  1  pop request; the head entry is removed when accepted.
- data_o  output  SIZE  current head entry (first-word-fall-through).
- full_o  output  1  high when count_o == DEPTH.
- empty_o  output  1  high when count_o == 0.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o  output  1  one-cycle strobe: write_i rejected in the previous cycle.
- underflow_o  output  1  one-cycle strobe: read_i rejected in the previous cycle.

Behaviour:
- Reset (asynchronous, on reset_i high, independent of clk): wr_ptr = rd_ptr = 0, count_o = 0, empty_o = 1, full_o = 0, overflow_o = 0, underflow_o = 0, data_o = 0. Storage contents need not be cleared but must never be visible while empty.
- Reset mid-operation discards all queued entries immediately; the first write after deassertion lands in entry 0.
- Accept rules are evaluated on state at the rising edge, before update:
  - write accepted iff write_i && !full_o.
  - read accepted iff read_i && !empty_o.
- Accepted write: mem[wr_ptr] <= data_i; wr_ptr increments modulo DEPTH (wrap DEPTH-1 -> 0).
- Accepted read: rd_ptr increments modulo DEPTH.
- count_o next value = count_o + accepted_write - accepted_read. Outputs full_o and empty_o are derived from the registered count; no combinational path from write_i or read_i to them.
- data_o is driven combinationally from mem[rd_ptr] when !empty_o, otherwise 0.
  - Latency from write to data_o visibility on an empty FIFO: 1 cycle (visible after the accepting edge).
  - After an accepted read, the next entry is visible immediately after the edge.
- Simultaneous write_i and read_i:
  - Neither full nor empty: both accepted; count unchanged; pointers both advance.
  - Full: read accepted, write rejected (no bypass of full), overflow_o = 1 next cycle, count = DEPTH-1.
  - Empty: write accepted, read rejected (no fall-through bypass), underflow_o = 1 next cycle, count = 1.
- Rejected operations never modify storage, pointers or count.
- overflow_o and underflow_o are registered, asserted for exactly one cycle per rejected request, and cleared the following cycle unless re-triggered.
- No X on any output after reset, regardless of X on data_i when write_i = 0.

Test Plan:
- Reset: SIZE=8, DEPTH=4; assert reset_i for 2 cycles mid-clock, no clk edge required -> count_o=0, empty_o=1, full_o=0, data_o=8'h00, both strobes 0.
- Fill/drain order: write 8'hA1, 8'hB2, 8'hC3, 8'hD4 on consecutive cycles -> full_o=1, count_o=4, data_o=8'hA1. Then read 4 cycles -> data_o sequence A1, B2, C3, D4, then empty_o=1, data_o=8'h00.
- Overflow: when full, assert write_i with 8'hEE -> overflow_o=1 for one cycle, count_o stays 4. Later read sequence contains no 8'hEE.
- Underflow and wrap: from empty, assert read_i -> underflow_o=1 for one cycle, count_o=0. Then run 10 cycles of alternating writes and reads with incrementing values 8'h00..8'h09 so the pointers wrap past 3 -> read data matches write order exactly.
- Simultaneous operations:
  - Empty with write_i+read_i (8'h55) -> count_o=1, data_o=8'h55, underflow_o=1.
  - Full with write_i+read_i -> count_o=3, overflow_o=1, head advances.
  - Count 2 with write_i+read_i -> count_o stays 2.
- Reset mid-operation: with count_o=3, pulse reset_i between edges -> count_o=0 at once. Then write 8'h77 -> data_o=8'h77, count_o=1.
